reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of each register and of every data port.
REQ-002 Parameter ADDR_WIDTH, default 5, width of every address port; register count is 2^ADDR_WIDTH (32 by default).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 waddr  input  ADDR_WIDTH  write address.
REQ-006 wen  input  1  write enable, active-high.
REQ-007 wdata  input  DATA_WIDTH  write data.
REQ-008 raddr1  input  ADDR_WIDTH  read port 1 address.
REQ-009 raddr2  input  ADDR_WIDTH  read port 2 address.
REQ-010 rdata1  output  DATA_WIDTH  read port 1 data.
REQ-011 rdata2  output  DATA_WIDTH  read port 2 data.

Function
REQ-012 The block SHALL hold 2^ADDR_WIDTH registers of DATA_WIDTH bits each.
REQ-013 Register 0 SHALL always read as 0; writes to address 0 SHALL be ignored.
REQ-014 On a rising clk edge with rst=0, wen=1 and waddr!=0, register[waddr] SHALL take wdata.
REQ-015 On a rising clk edge with wen=0, no register SHALL change.
REQ-016 Reads SHALL be combinational with zero latency: rdata1=register[raddr1] and rdata2=register[raddr2], no clock needed.
REQ-017 Both read ports SHALL be independent; equal raddr1 and raddr2 SHALL return identical data.
REQ-018 No write-to-read bypass: a read of the address being written SHALL return the old value until the write edge, then the new value in the same cycle after the edge.
REQ-019 All registers SHALL be written only through the single write port; there SHALL be one write per cycle at most.
REQ-020 Outputs SHALL never be X once reset has been applied for at least one edge.

Reset
REQ-021 On a rising clk edge with rst=1, all registers SHALL clear to 0.
REQ-022 rst SHALL take priority over wen: a write requested in a reset cycle SHALL be discarded.
REQ-023 rst asserted between clock edges SHALL have no effect until the next rising edge (synchronous).
REQ-024 After reset, rdata1 and rdata2 SHALL read 0 for every address.
REQ-025 Reset may be asserted at any time, including mid-sequence of writes; state after the reset edge SHALL be all-zero regardless of prior writes.

Verification
REQ-026 Apply rst=1 for one edge, then read all 32 addresses on both ports -> every read returns 0x00000000.
REQ-027 rst=0, wen=1, waddr=3, wdata=0x00300000, one edge; raddr1=3 -> rdata1=0x00300000; raddr2=2 -> rdata2=0.
REQ-028 rst=0, wen=1, waddr=22, wdata=0x000D0000, one edge; raddr1=22, raddr2=22 -> both return 0x000D0000; raddr2=6 -> 0.
REQ-029 wen=1, waddr=0, wdata=0xFFFFFFFF, one edge; raddr1=0 -> 0x00000000.
REQ-030 Write 0x12345678 to address 5, then wen=0 with wdata=0xDEADBEEF, waddr=5, one edge -> address 5 still reads 0x12345678; then rst=1 with wen=1, waddr=5, wdata=0xAAAAAAAA, one edge -> address 5 reads 0.
REQ-031 Hold raddr1=7 with waddr=7, wdata=0x55; before the edge rdata1 shows the old value, after the edge it shows 0x55 without a further edge.

Source files
------------

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2-read/1-write register file with hardwired-zero register 0
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  wen,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic write_ok;

  // A write only lands when enabled and not aimed at the hardwired-zero slot.
  assign write_ok = wen && (waddr != '0);

  // Next-state: hold every register, overlay the single write-port update.
  always_comb begin
    regs_d = regs_q;
    if (write_ok) begin
      regs_d[waddr] = wdata;
    end
  end

  // State register: synchronous reset wins over any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational reads; address 0 is forced to zero, no write bypass.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) begin
      rdata1 = regs_q[raddr1];
    end
    if (raddr2 != '0) begin
      rdata2 = regs_q[raddr2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] waddr;
  logic          wen;
  logic [DW-1:0] wdata;
  logic [AW-1:0] raddr1;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;

  int tests_run;
  int tests_failed;

  logic [DW-1:0] model [NR];
  logic [DW-1:0] exp_q [$];

  reg_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .waddr  (waddr),
    .wen    (wen),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // Posedges fall on odd times; all sampling happens on even times.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return (a == '0) ? '0 : model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic do_edge();
    @(posedge clk);
    #1;
  endtask

  // Drive both read addresses, push the model's answers, then pop and compare.
  task automatic rd(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    raddr1 = a1;
    raddr2 = a2;
    exp_q.push_back(model_rd(a1));
    exp_q.push_back(model_rd(a2));
    #2;
    if (exp_q.size() < 2) begin
      check_eq({tag, "_sb_empty"}, DW'(exp_q.size()), DW'(2));
    end else begin
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      check_eq({tag, "_rd1"}, rdata1, e1);
      check_eq({tag, "_rd2"}, rdata2, e2);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    waddr = a;
    wdata = d;
    wen   = 1'b1;
    do_edge();
    wen   = 1'b0;
    if (a != '0) model[a] = d;
  endtask

  initial begin
    logic [DW-1:0] old7;
    logic [AW-1:0] ra;
    logic [DW-1:0] rv;
    tests_run    = 0;
    tests_failed = 0;
    rst    = 1'b1;
    wen    = 1'b0;
    waddr  = '0;
    wdata  = '0;
    raddr1 = '0;
    raddr2 = '0;
    model_clear();

    // Reset for one edge, then every address reads zero on both ports.
    do_edge();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) rd("reset_all", AW'(i), AW'(NR - 1 - i));

    // Basic writes and a dual read of the same address.
    wr(5'd3, 32'h0030_0000);
    rd("w3", 5'd3, 5'd2);
    wr(5'd22, 32'h000D_0000);
    rd("w22_same", 5'd22, 5'd22);
    rd("w22_other", 5'd22, 5'd6);

    // Writes to address 0 are ignored.
    wr(5'd0, 32'hFFFF_FFFF);
    rd("w0", 5'd0, 5'd0);

    // wen=0 holds state; reset discards a simultaneous write.
    wr(5'd5, 32'h1234_5678);
    waddr = 5'd5;
    wdata = 32'hDEAD_BEEF;
    wen   = 1'b0;
    do_edge();
    rd("wen0_hold", 5'd5, 5'd3);
    rst   = 1'b1;
    wen   = 1'b1;
    waddr = 5'd5;
    wdata = 32'hAAAA_AAAA;
    do_edge();
    rst = 1'b0;
    wen = 1'b0;
    model_clear();
    rd("rst_beats_wen", 5'd5, 5'd22);

    // No bypass: old value before the edge, new value right after it.
    wr(5'd7, 32'h0000_1111);
    old7   = model[7];
    waddr  = 5'd7;
    wdata  = 32'h0000_0055;
    wen    = 1'b1;
    rd("bypass_before", 5'd7, 5'd7);
    check_eq("bypass_before_const", rdata1, old7);
    @(posedge clk);
    #1;
    wen = 1'b0;
    model[7] = 32'h0000_0055;
    rd("bypass_after", 5'd7, 5'd7);

    // Reset raised between edges has no effect until the edge.
    wr(5'd9, 32'hCAFE_F00D);
    rst = 1'b1;
    rd("rst_midcycle", 5'd9, 5'd7);
    do_edge();
    rst = 1'b0;
    model_clear();
    rd("rst_applied", 5'd9, 5'd7);

    // Random writes and reads against the model, reset mid-sequence.
    for (int n = 0; n < 300; n++) begin
      ra = AW'($urandom_range(0, NR - 1));
      rv = DW'($urandom);
      wr(ra, rv);
      rd("rand", AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)));
      if (n == 150) begin
        rst = 1'b1;
        wen = 1'b1;
        waddr = 5'd1;
        wdata = 32'h5A5A_5A5A;
        do_edge();
        rst = 1'b0;
        wen = 1'b0;
        model_clear();
        for (int i = 0; i < NR; i++) rd("rand_rst", AW'(i), AW'(i));
      end
    end

    check_eq("sb_drained", DW'(exp_q.size()), DW'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
